// File: rtl/spiflash_xip_ctrl.sv
// spiflash_xip_ctrl: SPI flash word-read master with single 03h and quad EBh continuous-read (XIP) paths
module spiflash_xip_ctrl #(
  parameter int CLK_DIV   = 2,
  parameter int DUMMY_CYC = 8,
  parameter int CSH_CYC   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  input  logic        cfg_quad,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic [3:0]  flash_io_oe,
  output logic [3:0]  flash_io_do,
  input  logic [3:0]  flash_io_di
);
  typedef enum logic [3:0] {INIT_MBR, INIT_WAKE, IDLE, MBR, CMD, ADDR, MODE, DUMMY, DATA, DESEL} state_t;
  state_t state, state_n, after, after_n;
  logic [15:0] div, cnt, len;
  logic [23:0] addr, addr_n;
  logic [31:0] sh_out, sh_in, load;
  logic sck, quad, quad_n, xip_active, shifting, tick, rise, fall, last, wide;
  // Reset parks in DESEL so chip select is high immediately, then DESEL hands over to the init MBR
  always_ff @(posedge clk)
    if (reset) begin
      state <= DESEL;
      after <= INIT_MBR;
    end else begin
      state <= state_n;
      after <= after_n;
    end
  // SCK edge decode, phase lengths, next-state selection and pin drive
  always_comb begin
    shifting = !(state inside {IDLE, DESEL});
    tick = shifting && div == 16'(CLK_DIV - 1);
    rise = tick && !sck;
    fall = tick && sck;
    wide = quad && state inside {ADDR, MODE, DUMMY, DATA};
    len = state == ADDR ? (quad ? 16'd6 : 16'd24) : state == MODE ? 16'd2 :
          state == DUMMY ? 16'(DUMMY_CYC) : state == DATA ? (quad ? 16'd8 : 16'd32) : 16'd8;
    last = fall && cnt == len - 16'd1;
    state_n = state;
    after_n = after;
    quad_n = quad;
    addr_n = addr;
    if (state == IDLE && req_valid) begin
      quad_n = cfg_quad;
      addr_n = req_addr & ~24'd3;
      state_n = xip_active ? (cfg_quad ? ADDR : MBR) : CMD;
    end else if (state == DESEL && cnt == 16'(CSH_CYC - 1))
      state_n = after;
    else if (last) begin
      state_n = state == CMD ? ADDR : state == ADDR ? (quad ? MODE : DATA) :
                state == MODE ? DUMMY : state == DUMMY ? DATA : DESEL;
      after_n = state == INIT_MBR ? INIT_WAKE : state == MBR ? CMD : IDLE;
    end
    load = state_n inside {INIT_MBR, MBR} ? '1 : state_n == INIT_WAKE ? {8'hAB, 24'h0} :
           state_n == CMD ? {quad_n ? 8'hEB : 8'h03, 24'h0} : state_n == ADDR ? {addr_n, 8'h0} :
           state_n == MODE ? {8'hA5, 24'h0} : '0;
    req_ready = state == IDLE;
    busy = state != IDLE;
    flash_csb = state inside {IDLE, DESEL};
    flash_clk = sck;
    flash_io_oe = state inside {INIT_MBR, INIT_WAKE, MBR, CMD} ? 4'b0001 :
                  state inside {ADDR, MODE} ? (wide ? 4'b1111 : 4'b0001) :
                  state == DATA && !quad ? 4'b0001 : 4'b0000;
    flash_io_do = (wide ? sh_out[31:28] : {3'b000, sh_out[31]}) & flash_io_oe;
  end
  // Divider, bit counting, MSB-first shifting on SCK fall, sampling on SCK rise, response capture
  always_ff @(posedge clk)
    if (reset) begin
      div <= '0;
      cnt <= '0;
      sck <= 1'b0;
      quad <= 1'b0;
      addr <= '0;
      xip_active <= 1'b0;
      sh_out <= '0;
      sh_in <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
    end else begin
      rsp_valid <= last && state == DATA;
      div <= tick || !shifting ? '0 : div + 16'd1;
      sck <= sck ^ tick;
      quad <= quad_n;
      addr <= addr_n;
      if (rise && state == DATA) sh_in <= quad ? {sh_in[27:0], flash_io_di} : {sh_in[30:0], flash_io_di[1]};
      if (state_n != state) begin
        cnt <= '0;
        sh_out <= load;
      end else if (state == DESEL)
        cnt <= cnt + 16'd1;
      else if (fall) begin
        cnt <= cnt + 16'd1;
        sh_out <= wide ? sh_out << 4 : sh_out << 1;
      end
      if (last && state == DATA) rsp_data <= {sh_in[7:0], sh_in[15:8], sh_in[23:16], sh_in[31:24]};
      if (last && state == MODE) xip_active <= 1'b1;
      else if (last && state inside {INIT_MBR, MBR}) xip_active <= 1'b0;
    end
endmodule

// File: tb/tb_spiflash_xip_ctrl.sv
// tb_spiflash_xip_ctrl: scoreboard bench for spiflash_xip_ctrl with a behavioural SPI flash model
module tb_spiflash_xip_ctrl;
  localparam int CSH = 4;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, cfg_quad = 1'b0;
  logic [23:0] req_addr = '0;
  logic req_ready, rsp_valid, busy, flash_csb, flash_clk;
  logic [31:0] rsp_data;
  logic [3:0] flash_io_oe, flash_io_do, pins;
  logic [3:0] f_drv = '0, f_oe = '0;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  int tr_rc[$];
  int tr_abase[$];
  logic [7:0] tr_cmd[$];
  logic [23:0] tr_addr[$];
  logic [7:0] mem [0:1023];
  int rc = 0, kind = 0, abase = 8, hi = 0, csh_viol = 0, contention = 0, rsp_cnt = 0;
  logic [7:0] m_cmd = '0, m_mode = '0;
  logic [23:0] m_addr = '0;
  logic m_xip = 1'b0;

  always #5 clk = ~clk;

  spiflash_xip_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .cfg_quad(cfg_quad), .busy(busy),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io_oe(flash_io_oe),
    .flash_io_do(flash_io_do), .flash_io_di(f_drv)
  );

  // undriven pins read as pulled high, as on a real board
  assign pins = (flash_io_do & flash_io_oe) | ~flash_io_oe;

  always @(negedge flash_csb) begin
    rc = 0;
    kind = m_xip ? 2 : 0;
    abase = m_xip ? 0 : 8;
    m_cmd = '0;
    m_addr = '0;
    m_mode = '0;
  end

  always @(posedge flash_csb) begin
    f_oe = '0;
    if (rc > 0) begin
      tr_rc.push_back(rc);
      tr_cmd.push_back(m_cmd);
      tr_addr.push_back(m_addr);
      tr_abase.push_back(abase);
      m_xip = kind == 2 && rc >= abase + 8 && m_mode == 8'hA5;
    end
  end

  always @(posedge flash_clk) if (!flash_csb) begin
    if ((f_oe & flash_io_oe) != 4'b0000) contention++;
    if (kind == 0) begin
      m_cmd = {m_cmd[6:0], pins[0]};
      if (rc == 7) kind = m_cmd == 8'h03 ? 1 : m_cmd == 8'hEB ? 2 : 3;
    end else if (kind == 1 && rc < 32) m_addr = {m_addr[22:0], pins[0]};
    else if (kind == 2 && rc < abase + 6) m_addr = {m_addr[19:0], pins};
    else if (kind == 2 && rc < abase + 8) m_mode = {m_mode[3:0], pins};
    rc++;
  end

  always @(negedge flash_clk) if (!flash_csb) begin
    int j;
    logic [7:0] b;
    if (kind == 1 && rc >= 32) begin
      j = rc - 32;
      b = mem[(int'(m_addr) + j / 8) % 1024];
      f_oe = 4'b0010;
      f_drv = {2'b00, b[7 - j % 8], 1'b0};
    end else if (kind == 2 && rc >= abase + 16) begin
      j = rc - abase - 16;
      b = mem[(int'(m_addr) + j / 2) % 1024];
      f_oe = 4'b1111;
      f_drv = j % 2 == 0 ? b[7:4] : b[3:0];
    end
  end

  always @(posedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (flash_csb) hi++;
    else if (hi != 0) begin
      if (hi < CSH) csh_viol++;
      hi = 0;
    end
  end

  // scoreboard: each response pops the word expected when its request was driven
  always @(negedge clk) if (rsp_valid) begin
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL rsp_unexpected: got %h, no response expected", rsp_data);
    end else begin
      e = exp_q.pop_front();
      if (rsp_data !== e) begin
        errors++;
        $display("FAIL rsp_data: got %h expected %h", rsp_data, e);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at time limit 300000");
    $fatal(1, "timeout");
  end

  task automatic clear_tr();
    tr_rc.delete();
    tr_cmd.delete();
    tr_addr.delete();
    tr_abase.delete();
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready === 1'b1;
  endtask

  task automatic issue(input logic [23:0] a, input logic q, input logic [31:0] e);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = a;
    cfg_quad = q;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({flash_csb, flash_clk, flash_io_oe, flash_io_do, req_ready, rsp_valid, busy} !== 13'b1_0_0000_0000_0_0_1) begin
      errors++;
      $display("FAIL reset_outputs: csb=%b clk=%b oe=%b do=%b ready=%b rsp_valid=%b busy=%b, need 1 0 0000 0000 0 0 1",
               flash_csb, flash_clk, flash_io_oe, flash_io_do, req_ready, rsp_valid, busy);
    end
    checks++;
    if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h need 00000000", rsp_data); end
    clear_tr();
    reset = 1'b0;
    wait_ready(ok);
    checks++;
    if (!ok || busy !== 1'b0) begin errors++; $display("FAIL init_idle: ready=%b busy=%b, need 1 0", req_ready, busy); end
    checks++;
    if (tr_rc.size() != 2 || tr_rc[0] != 8 || tr_cmd[0] != 8'hFF) begin
      errors++;
      $display("FAIL init_mbr: %0d transactions, first %0d SCK byte %h, need 2 / 8 SCK / ff", tr_rc.size(), tr_rc[0], tr_cmd[0]);
    end
    checks++;
    if (tr_rc.size() != 2 || tr_rc[1] != 8 || tr_cmd[1] != 8'hAB) begin
      errors++;
      $display("FAIL init_wake: second transaction %0d SCK byte %h, need 8 SCK ab", tr_rc[1], tr_cmd[1]);
    end
  endtask

  task automatic test_single();
    bit ok;
    int c0 = rsp_cnt;
    clear_tr();
    issue(24'h000100, 1'b0, 32'hDF9B5713);
    wait_ready(ok);
    checks++;
    if (!ok || rsp_cnt - c0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_rsp: ready=%b rsp cycles=%0d pending=%0d, need 1 1 0", ok, rsp_cnt - c0, exp_q.size());
    end
    checks++;
    if (tr_rc.size() != 1 || tr_rc[0] != 64 || tr_cmd[0] != 8'h03 || tr_addr[0] != 24'h000100) begin
      errors++;
      $display("FAIL single_shape: n=%0d SCK=%0d cmd=%h addr=%h, need 1 64 03 000100", tr_rc.size(), tr_rc[0], tr_cmd[0], tr_addr[0]);
    end
  endtask

  task automatic test_quad();
    bit ok;
    int c0 = rsp_cnt;
    clear_tr();
    issue(24'h000200, 1'b1, 32'hD4C3B2A1);
    wait_ready(ok);
    checks++;
    if (!ok || rsp_cnt - c0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL quad_rsp: ready=%b rsp cycles=%0d pending=%0d, need 1 1 0", ok, rsp_cnt - c0, exp_q.size());
    end
    checks++;
    if (tr_rc.size() != 1 || tr_rc[0] != 32 || tr_cmd[0] != 8'hEB || tr_addr[0] != 24'h000200) begin
      errors++;
      $display("FAIL quad_shape: n=%0d SCK=%0d cmd=%h addr=%h, need 1 32 eb 000200", tr_rc.size(), tr_rc[0], tr_cmd[0], tr_addr[0]);
    end
    checks++;
    if (m_xip !== 1'b1 || dut.xip_active !== 1'b1) begin
      errors++;
      $display("FAIL quad_xip: flash xip=%b ctrl xip_active=%b, need 1 1", m_xip, dut.xip_active);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int c0 = rsp_cnt;
    clear_tr();
    issue(24'h000204, 1'b1, 32'h44332211);
    repeat (10) @(negedge clk);
    req_valid = 1'b1;
    req_addr = 24'h000300;
    cfg_quad = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    cfg_quad = 1'b1;
    wait_ready(ok1);
    issue(24'h000209, 1'b1, 32'h88776655);
    wait_ready(ok2);
    checks++;
    if (!ok1 || !ok2 || rsp_cnt - c0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_rsp: ready=%b%b rsp cycles=%0d pending=%0d, need 11 2 0", ok1, ok2, rsp_cnt - c0, exp_q.size());
    end
    checks++;
    if (tr_rc.size() != 2 || tr_rc[0] != 24 || tr_abase[0] != 0 || tr_addr[0] != 24'h000204) begin
      errors++;
      $display("FAIL b2b_first: n=%0d SCK=%0d cmdless=%0d addr=%h, need 2 24 0 000204", tr_rc.size(), tr_rc[0], tr_abase[0], tr_addr[0]);
    end
    checks++;
    if (tr_rc.size() != 2 || tr_rc[1] != 24 || tr_abase[1] != 0 || tr_addr[1] != 24'h000208) begin
      errors++;
      $display("FAIL b2b_second: SCK=%0d cmdless=%0d addr=%h, need 24 0 000208", tr_rc[1], tr_abase[1], tr_addr[1]);
    end
  endtask

  task automatic test_mode_switch();
    bit ok;
    int c0 = rsp_cnt;
    clear_tr();
    issue(24'h000100, 1'b0, 32'hDF9B5713);
    cfg_quad = 1'b1;
    wait_ready(ok);
    cfg_quad = 1'b0;
    checks++;
    if (!ok || rsp_cnt - c0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL switch_rsp: ready=%b rsp cycles=%0d pending=%0d, need 1 1 0", ok, rsp_cnt - c0, exp_q.size());
    end
    checks++;
    if (tr_rc.size() != 2 || tr_rc[0] != 8 || tr_abase[0] != 0) begin
      errors++;
      $display("FAIL switch_mbr: n=%0d first SCK=%0d xip-framed=%0d, need 2 8 0", tr_rc.size(), tr_rc[0], tr_abase[0]);
    end
    checks++;
    if (tr_rc.size() != 2 || tr_rc[1] != 64 || tr_cmd[1] != 8'h03 || tr_addr[1] != 24'h000100) begin
      errors++;
      $display("FAIL switch_read: SCK=%0d cmd=%h addr=%h, need 64 03 000100", tr_rc[1], tr_cmd[1], tr_addr[1]);
    end
    checks++;
    if (m_xip !== 1'b0 || dut.xip_active !== 1'b0) begin
      errors++;
      $display("FAIL switch_xip: flash xip=%b ctrl xip_active=%b, need 0 0", m_xip, dut.xip_active);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    int c0 = rsp_cnt;
    issue(24'h000100, 1'b0, 32'hDF9B5713);
    while (!(rc >= 40 && !flash_csb) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(rc >= 40 && !flash_csb)) begin errors++; $display("FAIL mid_reach_data: SCK count %0d csb=%b, need >=40 0", rc, flash_csb); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({flash_csb, flash_clk, flash_io_oe, rsp_valid, busy, req_ready} !== 9'b1_0_0000_0_1_0) begin
      errors++;
      $display("FAIL mid_abort: csb=%b clk=%b oe=%b rsp_valid=%b busy=%b ready=%b, need 1 0 0000 0 1 0",
               flash_csb, flash_clk, flash_io_oe, rsp_valid, busy, req_ready);
    end
    repeat (3) @(negedge clk);
    exp_q.delete();
    clear_tr();
    reset = 1'b0;
    wait_ready(ok);
    checks++;
    if (!ok || rsp_cnt != c0) begin errors++; $display("FAIL mid_no_rsp: ready=%b rsp cycles=%0d, need 1 0", ok, rsp_cnt - c0); end
    checks++;
    if (tr_rc.size() != 2 || tr_cmd[0] != 8'hFF || tr_cmd[1] != 8'hAB || tr_rc[0] != 8 || tr_rc[1] != 8) begin
      errors++;
      $display("FAIL mid_replay: n=%0d bytes %h %h SCK %0d %0d, need 2 ff ab 8 8", tr_rc.size(), tr_cmd[0], tr_cmd[1], tr_rc[0], tr_rc[1]);
    end
  endtask

  task automatic test_pin_hygiene();
    checks++;
    if (contention != 0) begin errors++; $display("FAIL bus_contention: %0d SCK edges with both sides driving, need 0", contention); end
    checks++;
    if (csh_viol != 0) begin errors++; $display("FAIL csb_high_time: %0d gaps shorter than %0d clk, need 0", csh_viol, CSH); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    {mem[256], mem[257], mem[258], mem[259]} = {8'h13, 8'h57, 8'h9B, 8'hDF};
    {mem[512], mem[513], mem[514], mem[515]} = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    {mem[516], mem[517], mem[518], mem[519]} = {8'h11, 8'h22, 8'h33, 8'h44};
    {mem[520], mem[521], mem[522], mem[523]} = {8'h55, 8'h66, 8'h77, 8'h88};
    test_reset();
    test_single();
    test_quad();
    test_back_to_back();
    test_mode_switch();
    test_reset_mid();
    test_pin_hygiene();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
